// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial BCD divider.
//   QW            quotient width (holds the largest dividend, 999)
//   DIGITS        BCD dividend digits received before the divisor nibble
//   state_t       control FSM states
//   DIV0_QUOTIENT quotient streamed when the divisor is zero
//   clamp_bcd     saturates a nibble to the BCD digit range 0..9
package serial_divider_pkg;

    localparam int unsigned QW     = 10;
    localparam int unsigned DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        OUT
    } state_t;

    localparam logic [QW-1:0] DIV0_QUOTIENT = 10'h3FF;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Nibble-in / bit-out stream interface of the serial divider.
//   in_valid   nibble strobe, high for 4 consecutive cycles per operation
//   in_data    hundreds, tens, units digit, then divisor
//   out_valid  high for QW consecutive cycles per result
//   out_data   quotient bit, MSB first, 0 while out_valid is low
// master: stimulus side; slave: divider side.
interface serial_divider_if;

    logic       in_valid;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/serial_divider_div_step.sv
// One restoring-division step (combinational).
//   rem      current partial remainder (< divisor)
//   dbit     next dividend bit, shifted into the remainder LSB
//   divisor  divisor, 1..9
//   q        quotient bit for this step
//   rem_nx   partial remainder after this step
module div_step (
    input  logic [4:0] rem,
    input  logic       dbit,
    input  logic [3:0] divisor,
    output logic       q,
    output logic [4:0] rem_nx
);

    logic [5:0] shifted;
    logic [4:0] diff;

    always_comb begin
        shifted = {rem, dbit};
        // shifted never exceeds 17, so the subtraction fits in 5 bits
        diff    = shifted[4:0] - {1'b0, divisor};
        q       = (shifted >= {2'b00, divisor});
        rem_nx  = q ? diff : shifted[4:0];
    end

endmodule

// File: rtl/serial_divider.sv
// Serial-in, serial-out decimal divider.
// Receives a 3-digit BCD dividend and a 1-digit divisor on four consecutive
// in_valid cycles, then streams the 10-bit binary quotient MSB first, one
// restoring-division step per cycle, starting the cycle after the divisor.
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active HIGH (name inherited)
//   bus    serial_divider_if slave: in_valid/in_data in, out_valid/out_data out
module serial_divider
    import serial_divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    serial_divider_if.slave bus
);

    state_t        state, state_nx;
    logic [3:0]    cnt;       // nibble index while loading, step index while streaming
    logic [QW-1:0] dvd;       // dividend accumulator, then MSB-first shift register
    logic [3:0]    divisor;
    logic [4:0]    rem;

    logic [3:0]    digit;
    logic          last_nibble;
    logic          last_step;
    logic          div0;
    logic [3:0]    idx;
    logic          q_bit;
    logic [4:0]    rem_nx;

    assign digit       = clamp_bcd(bus.in_data);
    assign last_nibble = (cnt == 4'(DIGITS));
    assign last_step   = (cnt == 4'(QW - 1));
    assign div0        = (divisor == 4'd0);
    assign idx         = 4'(QW - 1) - cnt;

    div_step u_step (
        .rem     (rem),
        .dbit    (dvd[QW-1]),
        .divisor (divisor),
        .q       (q_bit),
        .rem_nx  (rem_nx)
    );

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = LOAD;
            LOAD: begin
                if (!bus.in_valid)    state_nx = IDLE;
                else if (last_nibble) state_nx = OUT;
            end
            OUT:  if (last_step) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd <= QW'(digit);
                        cnt <= 4'd1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (last_nibble) begin
                            divisor <= digit;
                            cnt     <= '0;
                            rem     <= '0;
                        end else begin
                            dvd <= (dvd << 3) + (dvd << 1) + QW'(digit);
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                OUT: begin
                    dvd <= {dvd[QW-2:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    // a zero divisor would let the remainder grow unbounded
                    rem <= div0 ? '0 : rem_nx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = (state == OUT);
        bus.out_data  = 1'b0;
        if (state == OUT)
            bus.out_data = div0 ? DIV0_QUOTIENT[idx] : q_bit;
    end

endmodule

// File: tb/tb_serial_divider.sv
module tb_serial_divider;

    logic clk = 1'b0;
    logic rst_n;

    serial_divider_if bus ();

    serial_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: assembles each out_valid run and compares it with the scoreboard.
    int         nbits = 0;
    logic [9:0] sh    = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            nbits = 0;
        end else if (bus.out_valid) begin
            if (nbits == 10) begin
                check("run_length_over", nbits + 1, 10);
                nbits = 0;
            end
            sh = {sh[8:0], bus.out_data};
            nbits++;
            if (nbits == 10) begin
                if (exp_q.size() == 0) check("unexpected_result", int'(sh), -1);
                else                   check("quotient", int'(sh), int'(exp_q.pop_front()));
            end
        end else begin
            if (nbits != 0) check("run_length", nbits, 10);
            check("idle_out_data", int'(bus.out_data), 0);
            nbits = 0;
        end
    end

    // Drives the four nibbles from a negedge; returns at the negedge of t4.
    task automatic do_op(input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic [3:0] dv,
                         input logic [9:0] expq, input bit push);
        logic [3:0] nib [4];
        nib[0] = d2; nib[1] = d1; nib[2] = d0; nib[3] = dv;
        if (push) exp_q.push_back(expq);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = nib[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        check("start_latency", int'(bus.out_valid), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 14; i++) begin
            if (!bus.out_valid) break;
            @(negedge clk);
        end
        check("out_valid_fall", int'(bus.out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data",  int'(bus.out_data), 0);
        rst_n = 1'b0;
        @(negedge clk);

        do_op(4'd1, 4'd2, 4'd3, 4'd4, 10'd30,  1'b1); wait_idle();
        do_op(4'd9, 4'd9, 4'd9, 4'd1, 10'd999, 1'b1); wait_idle();
        do_op(4'd9, 4'd9, 4'd9, 4'd9, 10'd111, 1'b1); wait_idle();
        do_op(4'd0, 4'd0, 4'd5, 4'd7, 10'd0,   1'b1); wait_idle();
        do_op(4'd4, 4'd5, 4'd6, 4'd0, 10'd1023, 1'b1); wait_idle();
        do_op(4'hF, 4'd0, 4'd0, 4'hC, 10'd100, 1'b1); wait_idle();

        // back-to-back: second load starts in the first cycle with out_valid low
        do_op(4'd0, 4'd8, 4'd4, 4'd2, 10'd42, 1'b1); wait_idle();
        do_op(4'd2, 4'd5, 4'd6, 4'd8, 10'd32, 1'b1); wait_idle();

        // in_valid pulsed during OUT must be ignored
        do_op(4'd7, 4'd7, 4'd7, 4'd3, 10'd259, 1'b1);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("no_spurious_start", int'(bus.out_valid), 0);

        // load aborted by in_valid dropping after two nibbles
        bus.in_valid = 1'b1; bus.in_data = 4'd3; @(negedge clk);
        bus.in_data  = 4'd3; @(negedge clk);
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (6) @(negedge clk);
        check("short_load_no_output", int'(bus.out_valid), 0);

        // reset in cycle t7 aborts the result
        do_op(4'd3, 4'd3, 4'd3, 4'd3, 10'd111, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_abort_valid", int'(bus.out_valid), 0);
        check("reset_abort_data",  int'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        check("reset_no_residual", int'(bus.out_valid), 0);

        do_op(4'd0, 4'd4, 4'd2, 4'd6, 10'd7, 1'b1); wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_divider.md
Name: serial_divider

Overview:
- Serial-in, serial-out decimal divider.
- Over four consecutive in_valid cycles it receives a 3-digit BCD dividend and a 1-digit divisor.
- It then streams the 10-bit binary quotient out one bit per cycle, MSB first, producing one restoring-division quotient bit per cycle.
- Standalone datapath block driven by a stimulus/checker environment.

Parameters:
- DIGITS, 3, number of BCD dividend digits received before the divisor nibble.
- QW, 10, quotient width in bits; holds max dividend 999.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset (name kept from codebase; high = reset).
- in_valid  input  1  high for exactly 4 consecutive cycles per operation.
- in_data  input  4  one nibble per valid cycle.
- out_valid  output  1  high for exactly QW consecutive cycles per result.
- out_data  output  1  quotient bit, MSB first, valid only while out_valid=1; 0 otherwise.

Behaviour:
- Reset: rst_n=1 at a rising edge → state IDLE, all registers cleared, out_valid=0, out_data=0.
  - Reset mid-load or mid-output aborts the operation; no partial output follows.
- Input order, when in_valid=1, cycles t0..t3:
  - t0: hundreds digit.
  - t1: tens digit.
  - t2: units digit.
  - t3: divisor.
- Digit values 10..15 are clamped to 9, both for dividend digits and for the divisor.
- Dividend = 100*d2 + 10*d1 + d0, range 0..999, stored in 10 bits.
  - Accumulate per cycle as acc = acc*10 + digit.
- States:
  - IDLE: wait for in_valid → LOAD, capture t0.
  - LOAD: capture nibbles; after the 4th nibble (t3) → OUT.
  - OUT: QW cycles, then → IDLE.
- Timing:
  - out_valid rises in cycle t4, immediately after the last in_valid cycle.
  - It stays high t4..t13, then falls; fixed latency of 1 cycle.
- Restoring division, step i = 0..9, one per OUT cycle:
  - r' = {r, dividend[9-i]}.
  - If r' >= divisor: out_data=1, r = r' - divisor; else out_data=0, r = r'.
  - Remainder register is 5 bits (r < divisor ≤ 9, shifted r' ≤ 17). Initial r = 0.
  - out_data is driven registered or combinationally from the registered state; either is acceptable, but it must align with out_valid.
- Divisor 0: quotient forced to all ones (1111111111, i.e. 1023), streamed on the same timing.
- Remainder is computed internally but not output.
- in_valid asserted during OUT is ignored.
- A new operation may start the cycle after out_valid falls.
- in_valid asserted in IDLE always starts a new load.
- in_valid dropping during LOAD (fewer than 4 nibbles) → return to IDLE, no output.
- No outputs other than those listed; out_data = 0 whenever out_valid = 0.

Decomposition:
- Package serial_divider_pkg:
  - QW, DIGITS.
  - State enum {IDLE, LOAD, OUT}.
  - Constant DIV0_QUOTIENT = 10'h3FF.
  - Function clamp_bcd(4b) → 4b.
- One natural sub-module: div_step.
  - Combinational: inputs 5-bit r, 1 dividend bit, 4-bit divisor.
  - Outputs quotient bit and next r.
- Top holds FSM, nibble/step counter, dividend shift register, divisor register.

Test Plan:
- Digits 1,2,3, divisor 4 (123/4) → out_valid t4..t13, bits 0000011110 (30).
- 9,9,9 / 1 → 1111100111 (999); 9,9,9 / 9 → 0001101111 (111).
- 0,0,5 / 7 → 0000000000; divisor 0 with 4,5,6 → 1111111111.
- Clamp: nibbles F,0,0 / C → treated as 900/9 → 0001100100 (100).
- Back-to-back: second operation starts the cycle after out_valid falls → correct second result. in_valid pulsed during OUT is ignored and the first result is unchanged.
- Reset asserted mid-OUT (cycle t7) → out_valid=0 next cycle, no residual bits. Then a fresh 0,4,2 / 6 → 0000000111 (7).
